// File: rtl/minv_mdiv_pkg.sv
// Shared types for the word ring register: FSM state encoding and width helpers.
package minv_mdiv;

  typedef enum logic {
    IDLE = 1'b0,
    ROT  = 1'b1
  } ring_state_t;

  // Position and step counters need at least one bit even for tiny rings.
  function automatic int pos_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/word_ring_reg_stage.sv
// One WIDTH-bit word stage: an enabled register with synchronous active-high reset.
module word_reg_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/word_ring_reg.sv
// DEPTH-word shift/rotate ring with an automatic full-turn rotation, position,
// fill level and wrap/done pulses.
module word_ring_reg
  import minv_mdiv::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic [WIDTH-1:0]                     din,
  input  logic                                 shift_en,
  input  logic                                 rot_en,
  input  logic                                 rot_start,
  output logic [WIDTH-1:0]                     dout,
  output logic [WIDTH-1:0]                     head,
  output logic [minv_mdiv::pos_width(DEPTH)-1:0] pos,
  output logic [$clog2(DEPTH+1)-1:0]           fill,
  output logic                                 full,
  output logic                                 busy,
  output logic                                 wrap,
  output logic                                 done
);

  localparam int PW = minv_mdiv::pos_width(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(DEPTH - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  ring_state_t      state_reg, state_next;
  logic [PW-1:0]    pos_reg, cnt_reg;
  logic [FW-1:0]    fill_reg;
  logic             wrap_reg, done_reg;
  logic             shift_do, rot_do, step, done_next;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Stage 0 takes din on a shift and the tail word on a rotate.
  assign stage_d[0] = shift_do ? din : stage_q[DEPTH-1];

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_link
      assign stage_d[gi] = stage_q[gi-1];
    end
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      word_reg_stage #(.WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst | clr),
        .en  (step),
        .d   (stage_d[gi]),
        .q   (stage_q[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    shift_do   = 1'b0;
    rot_do     = 1'b0;
    done_next  = 1'b0;
    if (!clr) begin
      case (state_reg)
        IDLE: begin
          shift_do = shift_en;
          rot_do   = rot_en && !shift_en;
          if (rot_start && !shift_en) state_next = ROT;
        end
        ROT: begin
          rot_do = 1'b1;
          if (cnt_reg == POS_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = IDLE;
    end
  end

  assign step = shift_do | rot_do;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pos_reg  <= '0;
      cnt_reg  <= '0;
      fill_reg <= '0;
      wrap_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      wrap_reg <= step && (pos_reg == POS_LAST);
      done_reg <= done_next;
      if (step) begin
        pos_reg <= (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;
      end
      if (state_reg == ROT) begin
        cnt_reg <= (cnt_reg == POS_LAST) ? '0 : cnt_reg + 1'b1;
      end
      if (shift_do && fill_reg != FILL_MAX) begin
        fill_reg <= fill_reg + 1'b1;
      end
    end
  end

  assign dout = stage_q[DEPTH-1];
  assign head = stage_q[0];
  assign pos  = pos_reg;
  assign fill = fill_reg;
  assign full = (fill_reg == FILL_MAX);
  assign busy = (state_reg == ROT);
  assign wrap = wrap_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_word_ring_reg.sv
// Directed table-driven bench for word_ring_reg (default size) plus a small
// WIDTH=16/DEPTH=3 instance for the saturation and wrap sequence.
module tb_word_ring_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        rst, clr, shift_en, rot_en, rot_start;
  logic [31:0] din, dout, head;
  logic [2:0]  pos;
  logic [3:0]  fill;
  logic        full, busy, wrap, done;

  word_ring_reg dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .shift_en(shift_en),
    .rot_en(rot_en), .rot_start(rot_start), .dout(dout), .head(head),
    .pos(pos), .fill(fill), .full(full), .busy(busy), .wrap(wrap), .done(done)
  );

  // Small instance
  logic        rst2, clr2, shift2, rot2, start2;
  logic [15:0] din2, dout2, head2;
  logic [1:0]  pos2, fill2;
  logic        full2, busy2, wrap2, done2;

  word_ring_reg #(.WIDTH(16), .DEPTH(3)) dut2 (
    .clk(clk), .rst(rst2), .clr(clr2), .din(din2), .shift_en(shift2),
    .rot_en(rot2), .rot_start(start2), .dout(dout2), .head(head2),
    .pos(pos2), .fill(fill2), .full(full2), .busy(busy2), .wrap(wrap2), .done(done2)
  );

  typedef struct {
    logic        rst, clr, shift, rot, start;
    logic [31:0] din;
    logic [31:0] e_dout, e_head;
    int          e_pos, e_fill;
    logic        e_full, e_busy, e_wrap, e_done;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic r, c, s, ro, st, input logic [31:0] d,
                              input logic [31:0] ed, eh, input int ep, ef,
                              input logic efu, eb, ew, edn);
    vec_t v;
    v.rst = r; v.clr = c; v.shift = s; v.rot = ro; v.start = st; v.din = d;
    v.e_dout = ed; v.e_head = eh; v.e_pos = ep; v.e_fill = ef;
    v.e_full = efu; v.e_busy = eb; v.e_wrap = ew; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; shift_en = 1'b0; rot_en = 1'b0; rot_start = 1'b0; din = '0;
    rst2 = 1'b1; clr2 = 1'b0; shift2 = 1'b0; rot2 = 1'b0; start2 = 1'b0; din2 = '0;

    // reset state
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 0,0,0,0));
    // shift 1..8: dout reaches 1 after the 8th shift, single wrap
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0,0,1,0,0,i, (i == 8) ? 1 : 0, i, i % 8, i, i == 8, 0, i == 8, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,8,0,8, 1,0,0,0));
    // full turn: busy 8 cycles, dout 2..8,1, done right after the last step
    vecs.push_back(mk(0,0,0,0,1,0, 1,8,0,8, 1,1,0,0));
    for (int j = 1; j <= 8; j++)
      vecs.push_back(mk(0,0,0,0,0,0, (j == 8) ? 1 : j + 1, j, j % 8, 8,
                        1, j < 8, j == 8, j == 8));
    vecs.push_back(mk(0,0,0,0,0,0, 1,8,0,8, 1,0,0,0));
    // shift beats rot_en; shift beats rot_start
    vecs.push_back(mk(0,0,1,1,0,32'hA5, 2,32'hA5,1,8, 1,0,0,0));
    vecs.push_back(mk(0,0,1,0,1,32'h5A, 3,32'h5A,2,8, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 3,32'h5A,2,8, 1,0,0,0));
    // full turn aborted by clr in its 4th busy cycle
    vecs.push_back(mk(0,0,0,0,1,0, 3,32'h5A,2,8, 1,1,0,0));
    vecs.push_back(mk(0,0,1,1,1,32'hFF, 4,3,3,8, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 5,4,4,8, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 6,5,5,8, 1,1,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0));
    // reset in the middle of a shift stream
    vecs.push_back(mk(0,0,1,0,0,32'h11, 0,32'h11,1,1, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,32'h22, 0,32'h22,2,2, 0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,32'h33, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0));

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; clr = vecs[k].clr; shift_en = vecs[k].shift;
      rot_en = vecs[k].rot; rot_start = vecs[k].start; din = vecs[k].din;
      @(posedge clk);
      #1;
      $display("[TB] vec %0d: dout=%0h head=%0h pos=%0d fill=%0d full=%0b busy=%0b wrap=%0b done=%0b",
               k, dout, head, pos, fill, full, busy, wrap, done);
      chk("dout", k, dout, vecs[k].e_dout);
      chk("head", k, head, vecs[k].e_head);
      chk("pos",  k, {29'd0, pos}, vecs[k].e_pos);
      chk("fill", k, {28'd0, fill}, vecs[k].e_fill);
      chk("full", k, {31'd0, full}, {31'd0, vecs[k].e_full});
      chk("busy", k, {31'd0, busy}, {31'd0, vecs[k].e_busy});
      chk("wrap", k, {31'd0, wrap}, {31'd0, vecs[k].e_wrap});
      chk("done", k, {31'd0, done}, {31'd0, vecs[k].e_done});
    end

    // WIDTH=16, DEPTH=3: fill saturates at 3, pos 1,2,0 with wraps, dout lags by 3
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    chk("d3_rst_dout", 0, {16'd0, dout2}, 0);
    chk("d3_rst_fill", 0, {30'd0, fill2}, 0);
    rst2 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      shift2 = 1'b1;
      din2   = 16'h100 + 16'(i);
      @(posedge clk);
      #1;
      $display("[TB] d3 shift %0d: dout=%0h head=%0h pos=%0d fill=%0d wrap=%0b",
               i, dout2, head2, pos2, fill2, wrap2);
      chk("d3_head", i, {16'd0, head2}, 32'h100 + i);
      chk("d3_dout", i, {16'd0, dout2}, (i >= 3) ? 32'h100 + i - 2 : 0);
      chk("d3_pos",  i, {30'd0, pos2}, i % 3);
      chk("d3_fill", i, {30'd0, fill2}, (i < 3) ? i : 3);
      chk("d3_full", i, {31'd0, full2}, (i >= 3) ? 1 : 0);
      chk("d3_wrap", i, {31'd0, wrap2}, (i % 3 == 0) ? 1 : 0);
      chk("d3_busy", i, {31'd0, busy2}, 0);
    end
    shift2 = 1'b0;
    @(posedge clk);
    #1;
    chk("d3_wrap_clear", 11, {31'd0, wrap2}, 0);
    chk("d3_hold_pos", 11, {30'd0, pos2}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
